toggle_period_meter: RTL and testbench

TOGGLE_PERIOD_METER -- requirements
Module: toggle_period_meter

---
 rtl/toggle_period_meter_pkg.sv | 14 +
 rtl/toggle_period_meter_edge_sync.sv | 29 ++
 rtl/toggle_period_meter.sv | 95 +++++++++
 tb/tb_toggle_period_meter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/toggle_period_meter_pkg.sv
// Shared types and constants for the toggle period meter.
// Imported by the RTL and by the bench.
package toggle_period_meter_pkg;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_MEASURE,
    ST_STALL
  } state_t;

endpackage

// File: rtl/toggle_period_meter_edge_sync.sv
// Synchronizer for an asynchronous level plus a rising-edge detector.
// level is the synchronized copy; rise compares it with one more flop.
module edge_sync
  import toggle_period_meter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  r_dly;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], d};
      r_dly  <= r_sync[SYNC_DEPTH-1];
    end
  end

  assign level = r_sync[SYNC_DEPTH-1];
  assign rise  = level & ~r_dly;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures period and high time of a toggling input in clk cycles.
// Declares a stall when no rising edge arrives for TIMEOUT cycles.
module toggle_period_meter
  import toggle_period_meter_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             t_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             stalled
);

  localparam logic [WIDTH-1:0] LP_TIMEOUT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] LP_ONE     = WIDTH'(1);

  logic             w_level;
  logic             w_rise;
  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_hcnt;

  edge_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (t_in),
    .level (w_level),
    .rise  (w_rise)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hcnt    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      stalled   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_hcnt  <= '0;
        stalled <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_state <= ST_ARMED;
            r_cnt   <= '0;
            r_hcnt  <= '0;
          end
          ST_ARMED: begin
            if (w_rise) begin
              r_state <= ST_MEASURE;
              r_cnt   <= LP_ONE;
              r_hcnt  <= LP_ONE;
            end
          end
          // A rise on the cycle the count sits at TIMEOUT still captures.
          ST_MEASURE: begin
            if (w_rise) begin
              period    <= r_cnt;
              high_time <= r_hcnt;
              valid     <= 1'b1;
              r_cnt     <= LP_ONE;
              r_hcnt    <= LP_ONE;
            end else if (r_cnt == LP_TIMEOUT) begin
              r_state <= ST_STALL;
              stalled <= 1'b1;
            end else begin
              r_cnt  <= r_cnt + LP_ONE;
              r_hcnt <= r_hcnt + WIDTH'(w_level);
            end
          end
          ST_STALL: begin
            if (w_rise) begin
              r_state <= ST_MEASURE;
              stalled <= 1'b0;
              r_cnt   <= LP_ONE;
              r_hcnt  <= LP_ONE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_toggle_period_meter.sv
// Directed bench for toggle_period_meter with immediate assertions.
// Outputs are sampled 1 ns after each rising clk edge.
module tb_toggle_period_meter;
  import toggle_period_meter_pkg::*;

  localparam int W  = 16;
  localparam int TO = 50;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         t_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         stalled;

  int n_assert  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int vcount    = 0;
  int last_vcyc = 0;
  int gap       = 0;
  int v0        = 0;
  bit saw_stall = 1'b0;

  always #10 clk = ~clk;

  toggle_period_meter #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .t_in      (t_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .stalled   (stalled)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      gap       = cyc - last_vcyc;
      last_vcyc = cyc;
      vcount++;
    end
    if (stalled) saw_stall = 1'b1;
  endtask

  task automatic toggle(input int n);
    repeat (n) begin
      t_in = ~t_in;
      tick();
    end
  endtask

  task automatic sq(input int hi, input int lo, input int reps);
    repeat (reps) begin
      t_in = 1'b1;
      repeat (hi) tick();
      t_in = 1'b0;
      repeat (lo) tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    t_in  = 1'b0;
    repeat (3) tick();
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_valid", valid, 0);
    check("rst_stalled", stalled, 0);

    // toggle every clk: arm on first rise, then period 2 / high 1
    reset  = 1'b1;
    en     = 1'b1;
    vcount = 0;
    toggle(20);
    check("tog_vcount", vcount, 8);
    check("tog_gap", gap, 2);
    check("tog_period", period, 2);
    check("tog_high", high_time, 1);

    // 5 high / 5 low
    sq(5, 5, 4);
    check("sq55_period", period, 10);
    check("sq55_high", high_time, 5);
    check("sq55_gap", gap, 10);

    // en dropped for 4 cycles
    toggle(6);
    check("pre_en_period", period, 2);
    v0 = vcount;
    en = 1'b0;
    toggle(4);
    check("en_low_no_valid", vcount, v0);
    check("en_low_hold", period, 2);
    en = 1'b1;
    v0 = vcount;
    toggle(3);
    check("arm_edge_no_valid", vcount, v0);
    toggle(6);
    check("en_resume_valid", 32'(vcount > v0), 1);
    check("en_resume_period", period, 2);

    // stall after TO cycles without a rise
    toggle(6);
    t_in = 1'b1;
    for (int i = 0; i < 200 && !stalled; i++) tick();
    check("stall_reached", stalled, 1);
    check("stall_latency", cyc - last_vcyc, TO);
    check("stall_hold_period", period, 2);
    v0 = vcount;
    repeat (5) tick();
    check("stall_no_valid", vcount, v0);
    check("stall_level", stalled, 1);

    // resume: first rise re-arms only
    v0 = vcount;
    for (int i = 0; i < 10 && stalled; i++) toggle(1);
    check("stall_cleared", stalled, 0);
    check("rearm_no_valid", vcount, v0);
    toggle(2);
    check("second_rise_valid", valid, 1);
    check("resume_period", period, 2);

    // rise coincident with count reaching TO
    sq(25, 25, 2);
    saw_stall = 1'b0;
    sq(25, 25, 2);
    check("coin_no_stall", saw_stall, 0);
    check("coin_period", period, TO);
    check("coin_high", high_time, 25);
    check("coin_gap", gap, TO);

    // reset mid-measurement
    toggle(6);
    reset = 1'b0;
    #2;
    check("mid_rst_period", period, 0);
    check("mid_rst_high", high_time, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_stalled", stalled, 0);
    toggle(3);
    reset = 1'b1;
    v0    = vcount;
    toggle(4);
    check("post_rst_no_valid", vcount, v0);
    for (int i = 0; i < 10 && !valid; i++) toggle(1);
    check("post_rst_valid", valid, 1);
    check("post_rst_period", period, 2);
    check("post_rst_high", high_time, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
